// File: rtl/alu_serial_sequencer.sv
// Bit-serial sequencer around a 1-bit combinational ALU.
// Takes a WIDTH-bit operand pair plus a 3-bit op code in one cycle. Presents
// the operands to the ALU one bit per clock, LSB first. Reassembles the F bits
// into a WIDTH-bit result and signals completion with a one-cycle done pulse.
module alu_serial_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_m,
  input  logic             op_s1,
  input  logic             op_s0,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             alu_m,
  output logic             alu_s1,
  output logic             alu_s0,
  output logic             alu_a,
  output logic             alu_b,
  input  logic             alu_f
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Only the WIDTH-1 bits captured before the final one need storing; the
  // last F bit is merged directly into result on the completion edge.
  logic [WIDTH-2:0] r_sh;
  logic [2:0]       op_reg;
  logic [IDX_W-1:0] idx;

  // Control FSM plus operand/result shift registers, all updated together
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      op_reg <= '0;
      idx    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh   <= a_in;
            b_sh   <= b_in;
            op_reg <= {op_m, op_s1, op_s0};
            idx    <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          r_sh <= (WIDTH-1)'({alu_f, r_sh} >> 1);
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          idx  <= idx + 1'b1;
          if (idx == LAST) begin
            result <= {alu_f, r_sh};
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  assign {alu_m, alu_s1, alu_s0} = op_reg;
  assign alu_a = busy & a_sh[0];
  assign alu_b = busy & b_sh[0];

endmodule
